por_rst_seq: RTL and testbench
==============================

Name: por_rst_seq

Overview:
- Digital reset sequencer directly downstream of the POR block.
- Consumes the POR's active-high por output as its async reset, runs on the POR's osc_ck, and watches por_timed_out.
- Releases N_DOM domain resets one after another, each a programmable number of cycles after the last.
- Re-sequences on software request or brownout, and keeps sticky cause flags for firmware.

Parameters:
- N_DOM, 3, number of sequenced reset domains (1..8).
- CNT_W, 8, width of the stage delay counter.
- STAGE_DLY, 16, cycles between successive domain releases (1..2^CNT_W-1).
- HOLD_CYC, 8, minimum cycles all domains are held low on a software reset (1..2^CNT_W-1).

Ports:
- osc_ck  in  1  sequencer clock (POR oscillator clock).
- por  in  1  asynchronous active-high reset, driven by the POR output.
- por_timed_out  in  1  POR one-shot done, async to osc_ck; high means supply good.
- sw_rst_req  in  1  single-cycle software reset request, synchronous.
- flag_clr  in  1  single-cycle clear of the sticky flags, synchronous.
- rst_n  out  N_DOM  domain resets, active low; bit 0 is released first.
- all_rdy  out  1  high when every domain is released and the block is in RUN.
- por_flag  out  1  sticky: last reset cause was por.
- sw_flag  out  1  sticky: a software reset occurred.
- bo_flag  out  1  sticky: a brownout occurred (por_timed_out fell while running).

Behaviour:
- Sync: por_timed_out passes a 2-flop synchronizer (reset to 0) to give pto_s. All internal use is pto_s, so input-to-action latency is 2 cycles.
- Reset (por=1, async): state=WAIT_PWR, cnt=0, idx=0, rst_n=all 0, all_rdy=0, por_flag=1, sw_flag=0, bo_flag=0, sync flops=0.
- States:
  - WAIT_PWR: rst_n all 0. When pto_s=1, load cnt=STAGE_DLY, idx=0, go to RELEASE.
  - RELEASE: cnt decrements each cycle. When cnt reaches 1 (on the cycle it would become 0), rst_n[idx] goes to 1 at the next edge.
    - If idx<N_DOM-1: idx++, reload cnt=STAGE_DLY.
    - Else go to RUN.
    - Domain i is released (STAGE_DLY*(i+1)) cycles after WAIT_PWR exits.
  - RUN: all_rdy=1 (registered, rises with the entry to RUN). rst_n stays all 1.
  - HOLD: rst_n all 0, all_rdy 0, cnt counts HOLD_CYC down.
    - At expiry with pto_s=1: reload STAGE_DLY, idx=0, go to RELEASE.
    - At expiry with pto_s=0: go to WAIT_PWR.
- rst_n lower bits released in RELEASE stay 1 until an abort event. Release is monotonic: bit i is never 1 while bit i-1 is 0.
- Software reset:
  - sw_rst_req=1 in RELEASE or RUN: next cycle rst_n all 0, all_rdy 0, sw_flag=1, cnt=HOLD_CYC, go to HOLD.
  - Ignored in WAIT_PWR and HOLD; sw_flag is not set in those states.
- Brownout: pto_s=0 in RELEASE, RUN or HOLD goes to WAIT_PWR next cycle with rst_n all 0. bo_flag=1 if the state was RELEASE or RUN.
- Priority for simultaneous events: brownout > sw_rst_req > counter progress.
  - If both occur in the same cycle, only bo_flag is set and the state goes to WAIT_PWR.
- flag_clr clears por_flag, sw_flag and bo_flag next cycle. A set event in the same cycle wins (that flag ends at 1).
- por asserted mid-sequence immediately forces all outputs to reset values, asynchronously and with no clock needed.
- Counters never wrap. cnt is loaded only with STAGE_DLY or HOLD_CYC and stops at 0.

Test Plan:
- Power-up: por=1 for 5 cycles, then 0; por_timed_out rises at cycle 10. With STAGE_DLY=16, N_DOM=3, rst_n bits rise at cycles 12+16, 12+32 and 12+48, ±1 per the synchronizer. all_rdy rises with bit 2. por_flag=1, sw_flag=0, bo_flag=0.
- Software reset in RUN: 1-cycle sw_rst_req gives rst_n=000 next cycle, held 8 cycles (HOLD_CYC). Re-release at 16-cycle spacing; sw_flag=1.
- Brownout: drop por_timed_out while in RUN (and separately while idx=1 in RELEASE). rst_n=000 within 3 cycles, bo_flag=1, block waits in WAIT_PWR. Raising the input restarts the full sequence from bit 0.
- Simultaneous events: sw_rst_req in the same cycle pto_s falls leads to WAIT_PWR, bo_flag=1, sw_flag=0. flag_clr with sw_rst_req in the same cycle leaves sw_flag=1 and por_flag=0.
- Async por mid-RELEASE, asserted between clock edges: all outputs return to reset values with no clock edge. After release the sequence restarts cleanly.
- Ignore cases: sw_rst_req during WAIT_PWR and during HOLD causes no state change and no sw_flag set. Monotonic release (rst_n[i] ≤ rst_n[i-1]) holds for the whole run.

Source files
------------

// File: rtl/por_rst_seq.sv
// Sequences N_DOM active-low domain resets out of POR, one every STAGE_DLY osc_ck cycles.
// por_timed_out acts 2 cycles after it changes; re-sequences on sw_rst_req or brownout; sticky cause flags.
module por_rst_seq #(
  parameter int N_DOM     = 3,
  parameter int CNT_W     = 8,
  parameter int STAGE_DLY = 16,
  parameter int HOLD_CYC  = 8
) (
  input  logic             osc_ck,
  input  logic             por,
  input  logic             por_timed_out,
  input  logic             sw_rst_req,
  input  logic             flag_clr,
  output logic [N_DOM-1:0] rst_n,
  output logic             all_rdy,
  output logic             por_flag,
  output logic             sw_flag,
  output logic             bo_flag
);

  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [CNT_W-1:0] STG_LD  = CNT_W'(STAGE_DLY);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_DOM - 1);

  typedef enum logic [1:0] {WAIT_PWR, RELEASE, RUN, HOLD} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [N_DOM-1:0] rst_n_n;
  logic             all_rdy_n;
  logic             sw_set, bo_set;
  logic             pto_m, pto_s;

  always_ff @(posedge osc_ck or posedge por) begin
    if (por) begin
      pto_m <= 1'b0;
      pto_s <= 1'b0;
    end else begin
      pto_m <= por_timed_out;
      pto_s <= pto_m;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    rst_n_n   = rst_n;
    all_rdy_n = all_rdy;
    sw_set    = 1'b0;
    bo_set    = 1'b0;
    case (state)
      WAIT_PWR: begin
        rst_n_n   = '0;
        all_rdy_n = 1'b0;
        if (pto_s) begin
          state_n = RELEASE;
          cnt_n   = STG_LD;
          idx_n   = '0;
        end
      end
      RELEASE, RUN: begin
        // Brownout outranks a software request, which outranks counter progress.
        if (!pto_s) begin
          state_n   = WAIT_PWR;
          rst_n_n   = '0;
          all_rdy_n = 1'b0;
          cnt_n     = '0;
          idx_n     = '0;
          bo_set    = 1'b1;
        end else if (sw_rst_req) begin
          state_n   = HOLD;
          rst_n_n   = '0;
          all_rdy_n = 1'b0;
          cnt_n     = HOLD_LD;
          idx_n     = '0;
          sw_set    = 1'b1;
        end else if (state == RELEASE) begin
          if (cnt == CNT_W'(1)) begin
            rst_n_n[idx] = 1'b1;
            if (idx == LAST) begin
              state_n   = RUN;
              all_rdy_n = 1'b1;
              cnt_n     = '0;
            end else begin
              idx_n = idx + IDX_W'(1);
              cnt_n = STG_LD;
            end
          end else if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      end
      HOLD: begin
        rst_n_n   = '0;
        all_rdy_n = 1'b0;
        if (!pto_s) begin
          state_n = WAIT_PWR;
          cnt_n   = '0;
        end else if (cnt <= CNT_W'(1)) begin
          state_n = RELEASE;
          cnt_n   = STG_LD;
          idx_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n   = WAIT_PWR;
        rst_n_n   = '0;
        all_rdy_n = 1'b0;
        cnt_n     = '0;
        idx_n     = '0;
      end
    endcase
  end

  always_ff @(posedge osc_ck or posedge por) begin
    if (por) begin
      state    <= WAIT_PWR;
      cnt      <= '0;
      idx      <= '0;
      rst_n    <= '0;
      all_rdy  <= 1'b0;
      por_flag <= 1'b1;
      sw_flag  <= 1'b0;
      bo_flag  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      rst_n    <= rst_n_n;
      all_rdy  <= all_rdy_n;
      // A set in the same cycle as flag_clr leaves the flag at 1.
      por_flag <= por_flag & ~flag_clr;
      sw_flag  <= (sw_flag & ~flag_clr) | sw_set;
      bo_flag  <= (bo_flag & ~flag_clr) | bo_set;
    end
  end

endmodule

// File: tb/tb_por_rst_seq.sv
// Directed bench for por_rst_seq: power-up, software reset, brownout, event priority, async por.
module tb_por_rst_seq;
  localparam int N_DOM = 3;

  logic             osc_ck = 1'b0;
  logic             por = 1'b0;
  logic             por_timed_out = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic             flag_clr = 1'b0;
  logic [N_DOM-1:0] rst_n;
  logic             all_rdy;
  logic             por_flag;
  logic             sw_flag;
  logic             bo_flag;

  int errors = 0;
  int checks = 0;

  por_rst_seq #(.N_DOM(N_DOM), .CNT_W(8), .STAGE_DLY(16), .HOLD_CYC(8)) dut (
    .osc_ck(osc_ck), .por(por), .por_timed_out(por_timed_out), .sw_rst_req(sw_rst_req),
    .flag_clr(flag_clr), .rst_n(rst_n), .all_rdy(all_rdy), .por_flag(por_flag),
    .sw_flag(sw_flag), .bo_flag(bo_flag)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic tick();
    @(posedge osc_ck);
    #1;
  endtask

  task automatic test_reset();
    #1 por = 1'b1;
    #1;
    checks++;
    if ({rst_n, all_rdy, por_flag, sw_flag, bo_flag} !== 7'b000_0100) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000100", {rst_n, all_rdy, por_flag, sw_flag, bo_flag});
    end
    repeat (5) tick();
    por = 1'b0;
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rst_n, all_rdy, sw_flag} !== 5'b000_00) begin
      errors++;
      $display("FAIL wait_pwr_sw_ignored: rst_n/all_rdy/sw_flag got %b want 00000", {rst_n, all_rdy, sw_flag});
    end
  endtask

  // Expects WAIT_PWR with the synchronizer holding 0; leaves the block in RUN.
  task automatic test_power_up(input logic e_por, input logic e_sw, input logic e_bo);
    int rise[N_DOM];
    int exp_rise[N_DOM];
    int rdy_at;
    int mono_bad;
    exp_rise = '{19, 35, 51};
    for (int i = 0; i < N_DOM; i++) rise[i] = -1;
    rdy_at = -1;
    mono_bad = 0;
    por_timed_out = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      for (int i = 0; i < N_DOM; i++)
        if (rst_n[i] === 1'b1 && rise[i] < 0) rise[i] = n;
      for (int i = 1; i < N_DOM; i++)
        if (rst_n[i] === 1'b1 && rst_n[i-1] !== 1'b1) mono_bad++;
      if (all_rdy === 1'b1 && rdy_at < 0) rdy_at = n;
    end
    for (int i = 0; i < N_DOM; i++) begin
      checks++;
      if (rise[i] !== exp_rise[i]) begin
        errors++;
        $display("FAIL power_up_rise_bit%0d: got cycle %0d want %0d", i, rise[i], exp_rise[i]);
      end
    end
    checks++;
    if (rdy_at !== 51) begin
      errors++;
      $display("FAIL power_up_all_rdy: got cycle %0d want 51", rdy_at);
    end
    checks++;
    if (mono_bad !== 0) begin
      errors++;
      $display("FAIL power_up_monotonic: got %0d violations want 0", mono_bad);
    end
    checks++;
    if ({rst_n, all_rdy, por_flag, sw_flag, bo_flag} !== {4'b1111, e_por, e_sw, e_bo}) begin
      errors++;
      $display("FAIL power_up_final: got %b want %b", {rst_n, all_rdy, por_flag, sw_flag, bo_flag},
               {4'b1111, e_por, e_sw, e_bo});
    end
  endtask

  // From RUN: sw reset, flags cleared during HOLD, a second request in HOLD is ignored.
  task automatic test_sw_in_run();
    int rise[N_DOM];
    int exp_rise[N_DOM];
    exp_rise = '{25, 41, 57};
    for (int i = 0; i < N_DOM; i++) rise[i] = -1;
    for (int n = 1; n <= 65; n++) begin
      sw_rst_req = (n == 1 || n == 5);
      flag_clr   = (n == 2);
      tick();
      sw_rst_req = 1'b0;
      flag_clr   = 1'b0;
      for (int i = 0; i < N_DOM; i++)
        if (rst_n[i] === 1'b1 && rise[i] < 0) rise[i] = n;
      if (n == 1) begin
        checks++;
        if ({rst_n, all_rdy, sw_flag} !== 5'b000_01) begin
          errors++;
          $display("FAIL sw_enter_hold: rst_n/all_rdy/sw_flag got %b want 00001", {rst_n, all_rdy, sw_flag});
        end
      end
      if (n == 2) begin
        checks++;
        if ({por_flag, sw_flag} !== 2'b00) begin
          errors++;
          $display("FAIL flag_clr: por/sw flags got %b want 00", {por_flag, sw_flag});
        end
      end
    end
    for (int i = 0; i < N_DOM; i++) begin
      checks++;
      if (rise[i] !== exp_rise[i]) begin
        errors++;
        $display("FAIL sw_rerelease_bit%0d: got cycle %0d want %0d", i, rise[i], exp_rise[i]);
      end
    end
    checks++;
    if ({rst_n, all_rdy, sw_flag} !== 5'b111_10) begin
      errors++;
      $display("FAIL hold_sw_ignored: rst_n/all_rdy/sw_flag got %b want 11110", {rst_n, all_rdy, sw_flag});
    end
  endtask

  task automatic test_brownout_run();
    por_timed_out = 1'b0;
    tick();
    tick();
    checks++;
    if ({rst_n, all_rdy} !== 4'b1111) begin
      errors++;
      $display("FAIL bo_run_latency: rst_n/all_rdy got %b want 1111", {rst_n, all_rdy});
    end
    tick();
    checks++;
    if ({rst_n, all_rdy, bo_flag} !== 5'b000_01) begin
      errors++;
      $display("FAIL bo_run_abort: rst_n/all_rdy/bo_flag got %b want 00001", {rst_n, all_rdy, bo_flag});
    end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (8) tick();
    checks++;
    if ({rst_n, all_rdy, sw_flag, bo_flag} !== 6'b000_000) begin
      errors++;
      $display("FAIL bo_wait_pwr: rst_n/all_rdy/sw/bo got %b want 000000", {rst_n, all_rdy, sw_flag, bo_flag});
    end
  endtask

  task automatic test_simultaneous();
    por_timed_out = 1'b0;
    tick();
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if ({rst_n, all_rdy, sw_flag, bo_flag} !== 6'b000_001) begin
      errors++;
      $display("FAIL bo_beats_sw: rst_n/all_rdy/sw/bo got %b want 000001", {rst_n, all_rdy, sw_flag, bo_flag});
    end
    repeat (20) tick();
    checks++;
    if (rst_n !== 3'b000) begin
      errors++;
      $display("FAIL bo_beats_sw_wait: rst_n got %b want 000", rst_n);
    end
  endtask

  task automatic test_brownout_release();
    for (int n = 1; n <= 35; n++) begin
      por_timed_out = (n <= 25);
      flag_clr      = (n == 1);
      tick();
      flag_clr = 1'b0;
      if (n == 1) begin
        checks++;
        if (bo_flag !== 1'b0) begin
          errors++;
          $display("FAIL bo_rel_clear: bo_flag got %b want 0", bo_flag);
        end
      end
      if (n == 27) begin
        checks++;
        if (rst_n !== 3'b001) begin
          errors++;
          $display("FAIL bo_rel_before: rst_n got %b want 001", rst_n);
        end
      end
      if (n == 28) begin
        checks++;
        if ({rst_n, bo_flag} !== 4'b000_1) begin
          errors++;
          $display("FAIL bo_rel_abort: rst_n/bo_flag got %b want 0001", {rst_n, bo_flag});
        end
      end
    end
    checks++;
    if (rst_n !== 3'b000) begin
      errors++;
      $display("FAIL bo_rel_stays_low: rst_n got %b want 000", rst_n);
    end
  endtask

  task automatic test_por_mid_release();
    por_timed_out = 1'b1;
    repeat (25) tick();
    checks++;
    if (rst_n !== 3'b001) begin
      errors++;
      $display("FAIL por_mid_setup: rst_n got %b want 001", rst_n);
    end
    #3 por = 1'b1;
    #1;
    checks++;
    if ({rst_n, all_rdy, por_flag, sw_flag, bo_flag} !== 7'b000_0100) begin
      errors++;
      $display("FAIL por_async: got %b want 0000100", {rst_n, all_rdy, por_flag, sw_flag, bo_flag});
    end
    repeat (3) tick();
    checks++;
    if (rst_n !== 3'b000) begin
      errors++;
      $display("FAIL por_held: rst_n got %b want 000", rst_n);
    end
    por = 1'b0;
    test_power_up(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clr_vs_set();
    sw_rst_req = 1'b1;
    flag_clr   = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    flag_clr   = 1'b0;
    checks++;
    if ({rst_n, por_flag, sw_flag} !== 5'b000_01) begin
      errors++;
      $display("FAIL clr_vs_set: rst_n/por/sw got %b want 00001", {rst_n, por_flag, sw_flag});
    end
    repeat (60) tick();
    checks++;
    if ({rst_n, all_rdy, sw_flag} !== 5'b1111_1) begin
      errors++;
      $display("FAIL clr_vs_set_rerun: rst_n/all_rdy/sw got %b want 11111", {rst_n, all_rdy, sw_flag});
    end
  endtask

  initial begin
    test_reset();
    test_power_up(1'b1, 1'b0, 1'b0);
    test_sw_in_run();
    test_brownout_run();
    test_power_up(1'b0, 1'b0, 1'b0);
    test_simultaneous();
    test_brownout_release();
    test_por_mid_release();
    test_clr_vs_set();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
